// File: rtl/cnt_disp_sched_if.sv
// Signal bundle between cnt_disp_sched, its counters, the shared BCD converter
// and the 7-segment decoder.
interface cnt_disp_sched_if;
   logic [6:0] cnt_a;
   logic [6:0] cnt_b;
   logic       hold;
   logic [6:0] conv_cnt;
   logic [3:0] conv_d1;
   logic [3:0] conv_d0;
   logic [3:0] an;
   logic [3:0] digit;

   modport master (
      output cnt_a, cnt_b, hold, conv_d1, conv_d0,
      input  conv_cnt, an, digit
   );

   modport slave (
      input  cnt_a, cnt_b, hold, conv_d1, conv_d0,
      output conv_cnt, an, digit
   );
endinterface

// File: rtl/cnt_disp_sched.sv
// Shares one binary-to-BCD converter between counters A and B, snapshots both
// once per frame and multiplexes the four digits onto a common-anode display.
module cnt_disp_sched #(
   parameter int SCAN_DIV = 100000
) (
   input  logic              clk,
   input  logic              rst,
   cnt_disp_sched_if.slave   bus
);

   localparam int              PW       = $clog2(SCAN_DIV);
   localparam logic [PW-1:0]   PRESC_TC = PW'(SCAN_DIV - 1);

   localparam logic [1:0] ST_LOAD_A = 2'd0;
   localparam logic [1:0] ST_LOAD_B = 2'd1;
   localparam logic [1:0] ST_SCAN   = 2'd2;

   logic [1:0]    r_state;
   logic [PW-1:0] r_presc;
   logic [1:0]    r_idx;
   logic [3:0]    r_a_d1;
   logic [3:0]    r_a_d0;
   logic [3:0]    r_b_d1;
   logic [3:0]    r_b_d0;

   logic [6:0]    w_conv_cnt;
   logic [3:0]    w_an;
   logic [3:0]    w_digit;
   logic [7:0]    w_snap;

   // Over-range counts show as two dashes; the converter output is not trusted there.
   function automatic logic [7:0] snap_digits(input logic [6:0] cnt,
                                              input logic [3:0] d1,
                                              input logic [3:0] d0);
      logic [7:0] res;
      if (cnt > 7'd99) begin
         res = {4'hE, 4'hE};
      end else begin
         res = {d1, d0};
      end
      return res;
   endfunction

   assign w_snap = snap_digits(w_conv_cnt, bus.conv_d1, bus.conv_d0);

   // Frame sequencer: load A, load B, then scan four digit slots.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_LOAD_A;
         r_presc <= '0;
         r_idx   <= 2'd0;
         r_a_d1  <= 4'hF;
         r_a_d0  <= 4'hF;
         r_b_d1  <= 4'hF;
         r_b_d0  <= 4'hF;
      end else begin
         case (r_state)
            ST_LOAD_A: begin
               {r_a_d1, r_a_d0} <= w_snap;
               r_state          <= ST_LOAD_B;
            end
            ST_LOAD_B: begin
               {r_b_d1, r_b_d0} <= w_snap;
               r_state          <= ST_SCAN;
               r_presc          <= '0;
               r_idx            <= 2'd0;
            end
            ST_SCAN: begin
               if (r_presc == PRESC_TC) begin
                  r_presc <= '0;
                  r_idx   <= r_idx + 2'd1;
                  // hold only matters at the last slot's terminal count
                  if ((r_idx == 2'd3) && !bus.hold) begin
                     r_state <= ST_LOAD_A;
                  end
               end else begin
                  r_presc <= r_presc + PW'(1);
               end
            end
            default: begin
               r_state <= ST_LOAD_A;
            end
         endcase
      end
   end

   // Output decode of state, slot index and snapshots.
   always_comb begin
      w_conv_cnt = 7'd0;
      w_an       = 4'b1111;
      w_digit    = 4'hF;
      case (r_state)
         ST_LOAD_A: w_conv_cnt = bus.cnt_a;
         ST_LOAD_B: w_conv_cnt = bus.cnt_b;
         ST_SCAN: begin
            case (r_idx)
               2'd0: begin w_digit = r_b_d0; w_an = 4'b1110; end
               2'd1: begin w_digit = r_b_d1; w_an = 4'b1101; end
               2'd2: begin w_digit = r_a_d0; w_an = 4'b1011; end
               2'd3: begin w_digit = r_a_d1; w_an = 4'b0111; end
               default: begin w_digit = 4'hF; w_an = 4'b1111; end
            endcase
            // a blank digit keeps its anode dark
            if (w_digit == 4'hF) begin
               w_an = 4'b1111;
            end else begin
               w_an = w_an;
            end
         end
         default: begin
            w_conv_cnt = 7'd0;
         end
      endcase
   end

   assign bus.conv_cnt = w_conv_cnt;
   assign bus.an       = w_an;
   assign bus.digit    = w_digit;

endmodule
